// File: rtl/hex_syscall_resp.sv
// Syscall responder for the hex core: executes EXIT, WRITE and READ requests
// against byte-wide host streams and returns a single result word per request.
module hex_syscall_resp #(
    parameter int unsigned STREAM_WIDTH = 8
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_req_valid,
    output logic                    o_req_ready,
    input  logic [1:0]              i_req_syscall,
    input  logic [31:0]             i_req_arg0,
    input  logic [31:0]             i_req_arg1,
    output logic                    o_rsp_valid,
    input  logic                    i_rsp_ready,
    output logic [31:0]             o_rsp_data,
    output logic                    o_rsp_err,
    output logic                    o_tx_valid,
    input  logic                    i_tx_ready,
    output logic [7:0]              o_tx_data,
    output logic [STREAM_WIDTH-1:0] o_tx_stream,
    output logic                    o_rx_req,
    input  logic                    i_rx_valid,
    output logic [STREAM_WIDTH-1:0] o_rx_stream,
    input  logic [7:0]              i_rx_data,
    output logic                    o_exit,
    output logic [31:0]             o_exit_code,
    output logic [31:0]             o_tx_count,
    output logic [31:0]             o_rx_count
);

    localparam int unsigned WORD_W = 32;
    localparam int unsigned BYTE_W = 8;

    typedef enum logic [1:0] {
        SC_EXIT    = 2'd0,
        SC_WRITE   = 2'd1,
        SC_READ    = 2'd2,
        SC_ILLEGAL = 2'd3
    } syscall_t;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_TX   = 3'd1,
        ST_RX   = 3'd2,
        ST_RESP = 3'd3,
        ST_HALT = 3'd4
    } state_t;

    state_t                  state_q;
    logic                    tx_valid_q;
    logic                    rx_req_q;
    logic                    rsp_valid_q;
    logic [WORD_W-1:0]       rsp_data_q;
    logic                    rsp_err_q;
    logic [BYTE_W-1:0]       tx_data_q;
    logic [STREAM_WIDTH-1:0] stream_q;
    logic                    exit_q;
    logic [WORD_W-1:0]       exit_code_q;
    logic [WORD_W-1:0]       tx_count_q;
    logic [WORD_W-1:0]       rx_count_q;

    // Only the low stream bits of arg1 are carried to the host.
    logic unused_arg1;
    assign unused_arg1 = ^i_req_arg1;

    // Request sequencing; every output bit below is a register except ready.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_IDLE;
            tx_valid_q  <= 1'b0;
            rx_req_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            tx_data_q   <= '0;
            stream_q    <= '0;
            exit_q      <= 1'b0;
            exit_code_q <= '0;
            tx_count_q  <= '0;
            rx_count_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (i_req_valid) begin
                        tx_data_q <= i_req_arg0[BYTE_W-1:0];
                        stream_q  <= i_req_arg1[STREAM_WIDTH-1:0];
                        case (syscall_t'(i_req_syscall))
                            SC_WRITE: begin
                                state_q    <= ST_TX;
                                tx_valid_q <= 1'b1;
                            end
                            SC_READ: begin
                                state_q  <= ST_RX;
                                rx_req_q <= 1'b1;
                            end
                            SC_EXIT: begin
                                state_q     <= ST_RESP;
                                rsp_valid_q <= 1'b1;
                                rsp_data_q  <= i_req_arg0;
                                rsp_err_q   <= 1'b0;
                                exit_q      <= 1'b1;
                                exit_code_q <= i_req_arg0;
                            end
                            default: begin
                                state_q     <= ST_RESP;
                                rsp_valid_q <= 1'b1;
                                rsp_data_q  <= '0;
                                rsp_err_q   <= 1'b1;
                            end
                        endcase
                    end
                end
                ST_TX: begin
                    if (i_tx_ready) begin
                        state_q     <= ST_RESP;
                        tx_valid_q  <= 1'b0;
                        tx_count_q  <= tx_count_q + WORD_W'(1);
                        rsp_valid_q <= 1'b1;
                        rsp_data_q  <= '0;
                        rsp_err_q   <= 1'b0;
                    end
                end
                ST_RX: begin
                    if (i_rx_valid) begin
                        state_q     <= ST_RESP;
                        rx_req_q    <= 1'b0;
                        rx_count_q  <= rx_count_q + WORD_W'(1);
                        rsp_valid_q <= 1'b1;
                        rsp_data_q  <= {(WORD_W-BYTE_W)'(0), i_rx_data};
                        rsp_err_q   <= 1'b0;
                    end
                end
                ST_RESP: begin
                    if (i_rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= exit_q ? ST_HALT : ST_IDLE;
                    end
                end
                ST_HALT: state_q <= ST_HALT;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign o_req_ready = (state_q == ST_IDLE);
    assign o_rsp_valid = rsp_valid_q;
    assign o_rsp_data  = rsp_data_q;
    assign o_rsp_err   = rsp_err_q;
    assign o_tx_valid  = tx_valid_q;
    assign o_tx_data   = tx_data_q;
    assign o_tx_stream = stream_q;
    assign o_rx_req    = rx_req_q;
    assign o_rx_stream = stream_q;
    assign o_exit      = exit_q;
    assign o_exit_code = exit_code_q;
    assign o_tx_count  = tx_count_q;
    assign o_rx_count  = rx_count_q;

endmodule

// File: doc/hex_syscall_resp.md
# hex_syscall_resp

Responder for the hex core's `OPR SVC` system calls. The core issues one syscall request per `SVC` (syscall number plus argument words) and stalls until this block replies. The block carries out EXIT, WRITE and READ against byte-wide host/UART streams and returns the result word. It sits between the core's execute stage and the simulation host or UART bridge.

## Interface
Parameters:
- `STREAM_WIDTH`, default 8: width of the stream-id field carried to the host.

Ports:
- `i_clk` in 1: single clock; all logic is rising-edge.
- `i_rst_n` in 1: asynchronous, active-low reset.
- `i_req_valid` in 1: a syscall request is present.
- `o_req_ready` out 1: the block can accept a request.
- `i_req_syscall` in 2: `syscall_t` (EXIT=0, WRITE=1, READ=2; 3 is illegal).
- `i_req_arg0` in 32: exit code for EXIT; value for WRITE (low byte used).
- `i_req_arg1` in 32: stream id for WRITE/READ (low `STREAM_WIDTH` bits used).
- `o_rsp_valid` out 1: a response is present.
- `i_rsp_ready` in 1: the core accepts the response.
- `o_rsp_data` out 32: result word.
- `o_rsp_err` out 1: the request was an illegal syscall.
- `o_tx_valid` out 1, `i_tx_ready` in 1, `o_tx_data` out 8, `o_tx_stream` out `STREAM_WIDTH`: output byte stream.
- `o_rx_req` out 1, `i_rx_valid` in 1, `o_rx_stream` out `STREAM_WIDTH`, `i_rx_data` in 8: input byte stream.
- `o_exit` out 1: sticky; the program has exited.
- `o_exit_code` out 32: latched EXIT argument.
- `o_tx_count` out 32, `o_rx_count` out 32: bytes transferred since reset.

## Operation
- All handshakes are valid/ready. A transfer occurs on a rising edge where both signals are high.
- FSM states: IDLE, TX, RX, RESP, HALT.
- IDLE:
  - `o_req_ready` = 1.
  - On a request handshake, latch syscall, arg0[7:0] and arg1[STREAM_WIDTH-1:0].
  - Next state by syscall: WRITE → TX; READ → RX; EXIT → RESP; illegal (3) → RESP with err = 1.
- TX:
  - `o_tx_valid` = 1; `o_tx_data` and `o_tx_stream` come from the latched values and stay stable until `i_tx_ready`.
  - On the handshake, `o_tx_count` increments and the state goes to RESP with `o_rsp_data` = 0.
- RX:
  - `o_rx_req` = 1 and `o_rx_stream` = latched stream.
  - On the first cycle with `i_rx_valid`, capture `{24'b0, i_rx_data}`, increment `o_rx_count`, and go to RESP.
  - `i_rx_valid` is ignored in every other state.
- EXIT path:
  - On acceptance, `o_exit_code` ← arg0 and `o_exit` ← 1. Both are sticky until reset.
  - `o_rsp_data` = arg0.
- RESP:
  - `o_rsp_valid` = 1; `o_rsp_data` and `o_rsp_err` stay stable until `i_rsp_ready`.
  - On the handshake, go to IDLE, or to HALT if `o_exit` = 1.
- HALT: `o_req_ready` = 0 permanently. Only reset leaves HALT.
- Counters wrap from 0xFFFF_FFFF to 0.
- `o_req_ready` is 0 in every state except IDLE, so at most one request is outstanding.

## Timing
- Reset values:
  - FSM = IDLE.
  - All `*_valid`, `o_rx_req`, `o_exit` and `o_rsp_err` = 0.
  - All data outputs, `o_exit_code` and both counters = 0.
  - `o_req_ready` = 1 from the first cycle after reset deasserts.
- Request accepted at edge T:
  - `o_tx_valid` / `o_rx_req` / `o_rsp_valid` (EXIT or illegal) high from T+1.
  - `o_exit` high from T+1.
- A TX or RX handshake at edge U gives `o_rsp_valid` from U+1.
- Minimum WRITE round trip, with `i_tx_ready` and `i_rsp_ready` tied high: request at T, tx at T+1, rsp at T+2, next request accepted at T+3.
- No combinational path from any input to any output except `o_req_ready`, which is a decode of registered state.
- Reset asserted mid-operation (any state, including HALT):
  - All outputs drop asynchronously to their reset values.
  - A byte in flight is abandoned; no response is produced.

## Test plan
- WRITE 0x0000_0141 to stream 2, `i_tx_ready` tied high → one tx handshake with data 0x41 and stream 2; response data 0, err 0; `o_tx_count` = 1; round trip 3 cycles.
- WRITE with `i_tx_ready` held low for 5 cycles → `o_tx_valid`, data and stream stable for all 5 cycles; exactly one transfer; `o_req_ready` = 0 throughout.
- READ on stream 0, `i_rx_valid` with 0xFF after 3 cycles → response 0x0000_00FF; `o_rx_count` = 1; `i_rx_valid` pulses in IDLE are ignored and leave the count unchanged.
- EXIT with code 7, `i_rsp_ready` low for 2 cycles → `o_exit` = 1 and `o_exit_code` = 7 from T+1; response 7 held for 2 cycles; then `o_req_ready` stays 0 for 20 cycles despite `i_req_valid`.
- Illegal syscall 3 → response at T+1 with err = 1 and data 0; no tx or rx activity; returns to IDLE.
- Reset pulsed while in TX with `i_tx_ready` low → all outputs return to reset values; a following READ completes normally.
